// File: rtl/life_grid_engine.sv
// 4x4 Game-of-Life engine: per-cell load and B3/S23 evaluation into a shadow grid, then commit.
// Define LIFE_WRAP_EN for toroidal neighbour addressing; the default is a fixed dead border.
module life_grid_engine (
  input  logic        clka,
  input  logic        reset,
  input  logic        load_data,
  input  logic        read_data,
  input  logic        writeout,
  input  logic        restart,
  input  logic [3:0]  idx,
  input  logic        cell_in,
  output logic [15:0] grid,
  output logic [4:0]  pop,
  output logic [8:0]  gen_count,
  output logic        lose_sig,
  output logic        eval_valid
);

  logic [15:0] grid_q, grid_d;
  logic [15:0] nxt_q, nxt_d;
  logic [4:0]  pop_q, pop_d;
  logic [8:0]  gen_q, gen_d;
  logic        lose_q, lose_d;
  logic        eval_valid_q, eval_valid_d;

  logic [1:0]       row, col;
  logic [2:0][1:0]  nb_row, nb_col;
  logic [2:0]       nb_row_ok, nb_col_ok;
  logic [3:0]       nbr_cnt;
  logic             next_bit;

  function automatic logic [4:0] popcnt(input logic [15:0] v);
    logic [4:0] s;
    s = 5'd0;
    for (int k = 0; k < 16; k++) s = s + {4'd0, v[k]};
    return s;
  endfunction

  assign row = idx[3:2];
  assign col = idx[1:0];

  // Neighbour coordinates use 2-bit arithmetic, so row-1 / row+1 wrap modulo 4 naturally.
  always_comb begin
    nb_row[0] = row - 2'd1;
    nb_row[1] = row;
    nb_row[2] = row + 2'd1;
    nb_col[0] = col - 2'd1;
    nb_col[1] = col;
    nb_col[2] = col + 2'd1;
`ifdef LIFE_WRAP_EN
    nb_row_ok = 3'b111;
    nb_col_ok = 3'b111;
`else
    nb_row_ok = {row != 2'd3, 1'b1, row != 2'd0};
    nb_col_ok = {col != 2'd3, 1'b1, col != 2'd0};
`endif
  end

  always_comb begin
    nbr_cnt = 4'd0;
    for (int i = 0; i < 3; i++) begin
      for (int j = 0; j < 3; j++) begin
        if (!(i == 1 && j == 1) && nb_row_ok[i] && nb_col_ok[j]) begin
          nbr_cnt = nbr_cnt + {3'd0, grid_q[{nb_row[i], nb_col[j]}]};
        end
      end
    end
  end

  assign next_bit = (nbr_cnt == 4'd3) || ((nbr_cnt == 4'd2) && grid_q[idx]);

  always_comb begin
    grid_d       = grid_q;
    nxt_d        = nxt_q;
    gen_d        = gen_q;
    lose_d       = lose_q;
    eval_valid_d = 1'b0;
    if (restart) begin
      grid_d = 16'd0;
      nxt_d  = 16'd0;
      gen_d  = 9'd0;
      lose_d = 1'b0;
    end else if (writeout) begin
      grid_d = nxt_q;
      gen_d  = (gen_q == 9'd511) ? gen_q : gen_q + 9'd1;
      if ((nxt_q == 16'd0) || (nxt_q == grid_q)) lose_d = 1'b1;
    end else if (load_data) begin
      grid_d[idx] = cell_in;
      nxt_d[idx]  = cell_in;
    end else if (read_data) begin
      nxt_d[idx]   = next_bit;
      eval_valid_d = 1'b1;
    end
    // pop always mirrors the registered grid, so it follows loads and commits alike.
    pop_d = popcnt(grid_d);
  end

  always_ff @(posedge clka) begin
    if (reset) begin
      grid_q       <= 16'd0;
      nxt_q        <= 16'd0;
      pop_q        <= 5'd0;
      gen_q        <= 9'd0;
      lose_q       <= 1'b0;
      eval_valid_q <= 1'b0;
    end else begin
      grid_q       <= grid_d;
      nxt_q        <= nxt_d;
      pop_q        <= pop_d;
      gen_q        <= gen_d;
      lose_q       <= lose_d;
      eval_valid_q <= eval_valid_d;
    end
  end

  assign grid       = grid_q;
  assign pop        = pop_q;
  assign gen_count  = gen_q;
  assign lose_sig   = lose_q;
  assign eval_valid = eval_valid_q;

endmodule

// File: tb/tb_life_grid_engine.sv
// Directed bench for life_grid_engine: single-cycle vector table plus multi-cycle pattern runs.
module tb_life_grid_engine;

  logic        clka = 1'b0;
  logic        reset;
  logic        load_data, read_data, writeout, restart;
  logic [3:0]  idx;
  logic        cell_in;
  logic [15:0] grid;
  logic [4:0]  pop;
  logic [8:0]  gen_count;
  logic        lose_sig;
  logic        eval_valid;

  int total = 0;
  int bad   = 0;

  life_grid_engine dut (
    .clka       (clka),
    .reset      (reset),
    .load_data  (load_data),
    .read_data  (read_data),
    .writeout   (writeout),
    .restart    (restart),
    .idx        (idx),
    .cell_in    (cell_in),
    .grid       (grid),
    .pop        (pop),
    .gen_count  (gen_count),
    .lose_sig   (lose_sig),
    .eval_valid (eval_valid)
  );

  always #5 clka = ~clka;

  typedef struct {
    logic        ld, rd, wo, rs;
    logic [3:0]  ix;
    logic        ci;
    logic [15:0] g;
    logic [4:0]  p;
    logic [8:0]  gc;
    logic        l;
    logic        ev;
  } vec_t;

  vec_t vecs[13];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic chk_all(input string name, input logic [15:0] g, input logic [4:0] p,
                         input logic [8:0] gc, input logic l, input logic ev);
    chk({name, ".grid"}, 32'(grid), 32'(g));
    chk({name, ".pop"}, 32'(pop), 32'(p));
    chk({name, ".gen"}, 32'(gen_count), 32'(gc));
    chk({name, ".lose"}, 32'(lose_sig), 32'(l));
    chk({name, ".ev"}, 32'(eval_valid), 32'(ev));
  endtask

  // Inputs change 1 time unit after a rising edge; outputs are sampled at the same point.
  task automatic cyc(input logic ld, input logic rd, input logic wo, input logic rs,
                     input logic [3:0] ix, input logic ci);
    load_data = ld;
    read_data = rd;
    writeout  = wo;
    restart   = rs;
    idx       = ix;
    cell_in   = ci;
    @(posedge clka);
    #1;
    load_data = 1'b0;
    read_data = 1'b0;
    writeout  = 1'b0;
    restart   = 1'b0;
  endtask

  task automatic load_pattern(input logic [15:0] pat);
    cyc(1'b0, 1'b0, 1'b0, 1'b1, 4'd0, 1'b0);
    for (int i = 0; i < 16; i++) cyc(1'b1, 1'b0, 1'b0, 1'b0, 4'(i), pat[i]);
  endtask

  task automatic eval_all(input string name);
    for (int i = 0; i < 16; i++) begin
      cyc(1'b0, 1'b1, 1'b0, 1'b0, 4'(i), 1'b0);
      chk({name, ".ev_pulse"}, 32'(eval_valid), 32'd1);
    end
  endtask

  logic [15:0] wrap_exp;
  logic        wrap_lose;

  initial begin
    reset = 1'b1;
    load_data = 1'b0; read_data = 1'b0; writeout = 1'b0; restart = 1'b0;
    idx = 4'd0; cell_in = 1'b0;
    @(posedge clka);
    @(posedge clka);
    #1;
    chk_all("reset", 16'h0, 5'd0, 9'd0, 1'b0, 1'b0);
    reset = 1'b0;

    //         ld    rd    wo    rs    idx    ci    grid      pop   gen   lose  ev
    vecs[0]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd0,  1'b1, 16'h0001, 5'd1, 9'd0, 1'b0, 1'b0};
    vecs[1]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd15, 1'b1, 16'h8001, 5'd2, 9'd0, 1'b0, 1'b0};
    vecs[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd0,  1'b0, 16'h8000, 5'd1, 9'd0, 1'b0, 1'b0};
    vecs[3]  = '{1'b0, 1'b1, 1'b0, 1'b0, 4'd15, 1'b0, 16'h8000, 5'd1, 9'd0, 1'b0, 1'b1};
    vecs[4]  = '{1'b0, 1'b0, 1'b0, 1'b0, 4'd0,  1'b0, 16'h8000, 5'd1, 9'd0, 1'b0, 1'b0};
    vecs[5]  = '{1'b1, 1'b1, 1'b0, 1'b0, 4'd3,  1'b1, 16'h8008, 5'd2, 9'd0, 1'b0, 1'b0};
    vecs[6]  = '{1'b0, 1'b0, 1'b1, 1'b0, 4'd0,  1'b0, 16'h0008, 5'd1, 9'd1, 1'b0, 1'b0};
    vecs[7]  = '{1'b1, 1'b0, 1'b1, 1'b0, 4'd0,  1'b1, 16'h0008, 5'd1, 9'd2, 1'b1, 1'b0};
    vecs[8]  = '{1'b1, 1'b0, 1'b0, 1'b0, 4'd1,  1'b1, 16'h000A, 5'd2, 9'd2, 1'b1, 1'b0};
    vecs[9]  = '{1'b1, 1'b0, 1'b1, 1'b1, 4'd2,  1'b1, 16'h0000, 5'd0, 9'd0, 1'b0, 1'b0};
    vecs[10] = '{1'b0, 1'b1, 1'b0, 1'b0, 4'd0,  1'b0, 16'h0000, 5'd0, 9'd0, 1'b0, 1'b1};
    vecs[11] = '{1'b0, 1'b0, 1'b1, 1'b0, 4'd0,  1'b0, 16'h0000, 5'd0, 9'd1, 1'b1, 1'b0};
    vecs[12] = '{1'b0, 1'b0, 1'b0, 1'b1, 4'd0,  1'b0, 16'h0000, 5'd0, 9'd0, 1'b0, 1'b0};

    for (int v = 0; v < 13; v++) begin
      cyc(vecs[v].ld, vecs[v].rd, vecs[v].wo, vecs[v].rs, vecs[v].ix, vecs[v].ci);
      chk_all($sformatf("vec%0d", v), vecs[v].g, vecs[v].p, vecs[v].gc, vecs[v].l, vecs[v].ev);
    end

    // Blinker, then two more held-writeout commits of the now-static shadow.
    load_pattern(16'h0070);
    chk_all("blink_load", 16'h0070, 5'd3, 9'd0, 1'b0, 1'b0);
    eval_all("blink");
    chk("blink_grid_hold", 32'(grid), 32'h0070);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
    chk_all("blink", 16'h0222, 5'd3, 9'd1, 1'b0, 1'b0);
    writeout = 1'b1;
    @(posedge clka);
    @(posedge clka);
    #1;
    writeout = 1'b0;
    chk_all("blink_hold2", 16'h0222, 5'd3, 9'd3, 1'b1, 1'b0);

`ifdef LIFE_WRAP_EN
    wrap_exp  = 16'h0111;
    wrap_lose = 1'b0;
`else
    wrap_exp  = 16'h0000;
    wrap_lose = 1'b1;
`endif
    load_pattern(16'h00B0);
    eval_all("wrap");
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
    chk("wrap.grid", 32'(grid), 32'(wrap_exp));
    chk("wrap.lose", 32'(lose_sig), 32'(wrap_lose));
    chk("wrap.gen", 32'(gen_count), 32'd1);

    load_pattern(16'h0033);
    eval_all("still");
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
    chk_all("still", 16'h0033, 5'd4, 9'd1, 1'b1, 1'b0);

    load_pattern(16'h0070);
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 4'd5, 1'b0);
    chk("partial.ev", 32'(eval_valid), 32'd1);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
    chk_all("partial", 16'h0070, 5'd3, 9'd1, 1'b1, 1'b0);

    load_pattern(16'h0222);
    writeout = 1'b1;
    for (int n = 0; n < 600; n++) begin
      @(posedge clka);
      #1;
      if (n == 510) chk("sat.at511", 32'(gen_count), 32'd511);
    end
    writeout = 1'b0;
    chk_all("sat", 16'h0222, 5'd3, 9'd511, 1'b1, 1'b0);

    // Reset in the same cycle as a read, then in the same cycle as a writeout.
    load_pattern(16'h0070);
    reset = 1'b1;
    cyc(1'b0, 1'b1, 1'b0, 1'b0, 4'd5, 1'b0);
    reset = 1'b0;
    chk_all("rst_eval", 16'h0, 5'd0, 9'd0, 1'b0, 1'b0);
    cyc(1'b1, 1'b0, 1'b0, 1'b0, 4'd6, 1'b1);
    reset = 1'b1;
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
    reset = 1'b0;
    chk_all("rst_wo", 16'h0, 5'd0, 9'd0, 1'b0, 1'b0);
    cyc(1'b0, 1'b0, 1'b1, 1'b0, 4'd0, 1'b0);
    chk_all("rst_first_commit", 16'h0, 5'd0, 9'd1, 1'b1, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/life_grid_engine.md
LIFE_GRID_ENGINE -- requirements
Module: life_grid_engine

Interface
REQ-001 The block SHALL have input clka, 1 bit, the sole clock; all state SHALL update on its rising edge.
REQ-002 The block SHALL have input reset, 1 bit, synchronous, active-high.
REQ-003 The block SHALL have input load_data, 1 bit: write cell_in into cell idx.
REQ-004 The block SHALL have input read_data, 1 bit: evaluate the next-generation value of cell idx.
REQ-005 The block SHALL have input writeout, 1 bit: commit the evaluated generation.
REQ-006 The block SHALL have input restart, 1 bit: clear the grid and all counters.
REQ-007 The block SHALL have input idx, 4 bits: cell address, row = idx[3:2], col = idx[1:0].
REQ-008 The block SHALL have input cell_in, 1 bit: pattern bit used during load.
REQ-009 The block SHALL have output grid, 16 bits: current generation, bit n is cell n.
REQ-010 The block SHALL have output pop, 5 bits: live-cell count of grid, 0..16.
REQ-011 The block SHALL have output gen_count, 9 bits: committed generations.
REQ-012 The block SHALL have output lose_sig, 1 bit: extinction or still-life detected; this output feeds the game FSM's lose input.
REQ-013 The block SHALL have output eval_valid, 1 bit: pulses one cycle after each accepted read_data.

Function
REQ-014 The block SHALL hold two 16-bit registers: grid (current generation) and nxt (next-generation shadow).
REQ-015 Strobe priority SHALL be, per cycle: restart > writeout > load_data > read_data; lower-priority strobes asserted in the same cycle SHALL be ignored.
REQ-016 Load: in the cycle after load_data, grid[idx] and nxt[idx] SHALL both equal cell_in; no other bit SHALL change.
REQ-017 Evaluate: read_data SHALL compute the live-neighbour count of cell idx from grid (4-bit sum, range 0..8) and apply the B3/S23 rule.
REQ-018 Evaluate result: nxt[idx] SHALL be 1 when the count is 3, or when the count is 2 and grid[idx] = 1; otherwise 0.
REQ-019 Evaluate latency: nxt[idx] SHALL update in the next cycle and eval_valid SHALL be 1 for exactly that cycle; grid SHALL NOT change.
REQ-020 Unevaluated cells: any cell not evaluated since the last commit or load SHALL keep its nxt value, which equals grid.
REQ-021 Commit, one cycle after writeout: grid SHALL take the value of nxt and nxt SHALL hold its value, so that nxt equals the new grid.
REQ-022 Commit: gen_count SHALL increment by one and saturate at 511.
REQ-023 Commit: pop SHALL be the popcount of the new grid, valid in the same cycle as the new grid.
REQ-024 Commit: lose_sig SHALL set when the new grid equals 0, or when the new grid equals the old grid.
REQ-025 lose_sig SHALL be sticky until restart or reset.
REQ-026 A writeout held high for N cycles SHALL commit N times; each commit SHALL increment gen_count and apply the still-life check.
REQ-027 Restart: in the next cycle, grid, nxt, pop, gen_count, lose_sig and eval_valid SHALL be 0.
REQ-028 load_data while lose_sig = 1 SHALL still write the cell and SHALL NOT clear lose_sig.
REQ-029 pop SHALL also track loads, and SHALL be valid one cycle after each load.

Reset
REQ-030 When reset = 1 at a clka edge, every register and output SHALL go to 0, identical to restart.
REQ-031 reset SHALL override all strobes, including a reset asserted mid-evaluation or in the same cycle as writeout.
REQ-032 After reset, the first commit SHALL produce gen_count = 1.

Configuration
REQ-033 With macro LIFE_WRAP_EN defined, neighbour addressing SHALL be toroidal: row and col wrap modulo 4.
REQ-034 With LIFE_WRAP_EN undefined, neighbours outside rows/cols 0..3 SHALL count as dead, giving a fixed dead border.

Verification
REQ-035 The bench SHALL cover the blinker: load grid = 0x0070, read idx 0..15, writeout -> grid = 0x0222, pop = 3, gen_count = 1, lose_sig = 0 (both configurations).
REQ-036 The bench SHALL cover wrap: load 0x00B0, evaluate all 16 cells, writeout -> with LIFE_WRAP_EN grid = 0x0111, lose_sig = 0; without it grid = 0x0000, lose_sig = 1.
REQ-037 The bench SHALL cover still life: load block 0x0033, evaluate all cells, writeout -> grid = 0x0033, lose_sig = 1, gen_count = 1.
REQ-038 The bench SHALL cover priority: restart, writeout and load_data asserted in the same cycle -> next cycle all outputs = 0.
REQ-039 The bench SHALL cover saturation: 600 consecutive writeout cycles on 0x0222 -> gen_count = 511.
REQ-040 The bench SHALL cover partial evaluation: load 0x0070, read idx 5 only, writeout -> grid = 0x0070 (cell 5 survives, all others unchanged), lose_sig = 1.
